pxie_c2h_reader: RTL and testbench
==================================

Name: pxie_c2h_reader

Overview:
- Card-to-host readback engine; sits directly downstream of the PXIe RX command decoder and consumes its c2h_addr / c2h_len / c2h_en outputs.
- On a read-config command it emits a header word, then streams c2h_len 64-bit words from the system RAM read port onto the PXIe TX data path.
- Honours TX backpressure with a credit-limited skid FIFO.
- Reports busy and done status.

Parameters:
- RD_LAT, 2, RAM read latency in cycles from O_ram_rden to I_ram_data valid (1..4).
- FIFO_DEPTH, 4, skid FIFO entries; must be at least RD_LAT+1 (power of 2).
- ADDR_STEP, 2, RAM address increment per 64-bit word (matches the decoder's write stride).

Ports:
- I_PXIE_CLK  in  1  clock; all logic on rising edge.
- I_Rst  in  1  reset; synchronous, active-high.
- I_c2h_addr  in  16  start RAM address.
- I_c2h_len  in  16  number of 64-bit data words.
- I_c2h_en  in  1  start request; acts on its rising edge.
- O_ram_addr  out  16  RAM read address.
- O_ram_rden  out  1  RAM read strobe, one word per cycle.
- I_ram_data  in  64  RAM read data, valid RD_LAT cycles after rden.
- O_PXIE_TX_DATA  out  64  stream data (FIFO head).
- O_PXIE_TX_VLD  out  1  stream valid (FIFO not empty).
- I_PXIE_TX_RDY  in  1  sink ready; a word transfers when VLD and RDY are both high.
- O_busy  out  1  high from start until the last word transfers.
- O_done  out  1  one-cycle pulse on the last word's transfer cycle.

Behaviour:
- Reset: all outputs 0 (O_ram_addr=0, O_PXIE_TX_DATA=0, VLD=0, busy=0, done=0). FIFO flushed, rden valid pipe cleared, state IDLE.
- Reset mid-transfer: same as above. In-flight RAM returns are discarded. No partial frame resumes.
- Start detection: en_q registers I_c2h_en. Start when I_c2h_en=1 and en_q=0 in IDLE.
  - On the start edge, latch addr and len, go to HEAD, assert busy.
  - Start edges outside IDLE are ignored; no queuing.
- States:
  - IDLE: wait for start.
  - HEAD: push header {16'hEB9C, len[15:0], addr[15:0], 16'h1010} into the FIFO (always empty here), then go to READ. If len=0, go to DRAIN instead.
  - READ: issue reads while remaining>0 and credit<FIFO_DEPTH.
    - credit = FIFO occupancy + reads in flight.
    - Each issue: O_ram_rden=1, O_ram_addr=cur, cur<=cur+ADDR_STEP (16-bit, wraps modulo 2^16), remaining<=remaining-1.
    - Go to DRAIN after the final issue.
  - DRAIN: wait until in-flight=0 and FIFO empty. The last pop asserts O_done in that same cycle; next state IDLE, busy drops.
- Read return: a valid shift register of length RD_LAT tracks rden. Its tail pushes I_ram_data into the FIFO. The credit rule guarantees the FIFO never overflows.
- FIFO: first-word-fall-through.
  - Simultaneous push and pop is allowed, including when full (the pop frees the slot) and when empty (bypass not required; data visible the next cycle).
- Latency with RDY=1: start edge at cycle N → header on TX with VLD at N+2. First rden at N+2. First data word on TX at N+2+RD_LAT+1.
- Throughput: 1 word/cycle sustained when RDY=1 and FIFO_DEPTH >= RD_LAT+1.
- RDY low: TX data and VLD hold stable. rden stalls once credit reaches FIFO_DEPTH. Nothing is dropped or duplicated.
- O_ram_addr holds its last value while rden=0.

Decomposition:
- Shared package pxie_pkg:
  - header constants: HDR_SYNC=16'hEB9C, CMD_READCFG=16'h1010, CMD_ISA=16'h1000, CMD_SRAM=16'h1001, CMD_RST=16'h0001, CMD_TRIG=16'h0002;
  - state encoding for IDLE/HEAD/READ/DRAIN;
  - DATA_W=64, ADDR_W=16.
- Sub-module pxie_c2h_fifo: synchronous FWFT FIFO with occupancy count output, parameterised by depth and width.

Test Plan:
- addr=0x0010, len=4, RDY=1, RAM returns addr-derived data → TX shows header 0xEB9C_0004_0010_1010, then 4 words. rden addresses 0x10, 0x12, 0x14, 0x16. O_done on the 5th transfer; busy low the next cycle.
- len=0, addr=0x1234 → single word 0xEB9C_0000_1234_1010, no rden, O_done on that transfer.
- len=16, RDY held low 20 cycles after the header → at most FIFO_DEPTH reads issued (4 with defaults), TX data stable. After RDY=1, all 16 words arrive in order with no gaps once streaming.
- addr=0xFFFE, len=2 → rden addresses 0xFFFE then 0x0000.
- Second I_c2h_en pulse while busy with len=8 → ignored; exactly 9 words out. A pulse after done starts a new frame.
- I_Rst asserted mid-READ for 1 cycle → VLD=0 and busy=0 the next cycle, FIFO empty, late RAM returns not pushed. A new start produces a clean header.

Source files
------------

// File: rtl/pxie_pkg.sv
// Shared PXIe definitions: header words, command codes,
// readback FSM states and the bus widths.
package pxie_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 16;

    localparam logic [15:0] HDR_SYNC    = 16'hEB9C;
    localparam logic [15:0] CMD_READCFG = 16'h1010;
    localparam logic [15:0] CMD_ISA     = 16'h1000;
    localparam logic [15:0] CMD_SRAM    = 16'h1001;
    localparam logic [15:0] CMD_RST     = 16'h0001;
    localparam logic [15:0] CMD_TRIG    = 16'h0002;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } c2h_state_e;

    function automatic logic [DATA_W-1:0] c2h_header(
        input logic [15:0] len,
        input logic [15:0] addr
    );
        return {HDR_SYNC, len, addr, CMD_READCFG};
    endfunction

endpackage

// File: rtl/pxie_c2h_fifo.sv
// First-word-fall-through skid FIFO with occupancy count.
// Push while full is accepted only when a pop frees the slot.
module pxie_c2h_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     I_PXIE_CLK,
    input  logic                     I_Rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so stale entries never leak out
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge I_PXIE_CLK) begin
        if (I_Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge I_PXIE_CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pxie_c2h_reader.sv
// Card-to-host readback: header word then c2h_len RAM words,
// credit-limited so the skid FIFO absorbs all in-flight reads.
module pxie_c2h_reader
    import pxie_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 2
) (
    input  logic              I_PXIE_CLK,
    input  logic              I_Rst,
    input  logic [15:0]       I_c2h_addr,
    input  logic [15:0]       I_c2h_len,
    input  logic              I_c2h_en,
    output logic [15:0]       O_ram_addr,
    output logic              O_ram_rden,
    input  logic [63:0]       I_ram_data,
    output logic [63:0]       O_PXIE_TX_DATA,
    output logic              O_PXIE_TX_VLD,
    input  logic              I_PXIE_TX_RDY,
    output logic              O_busy,
    output logic              O_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    c2h_state_e        state_q;
    c2h_state_e        state_d;
    logic              en_q;
    logic [15:0]       cur_q;
    logic [15:0]       rem_q;
    logic [15:0]       addr_q;
    logic [RD_LAT-1:0] vld_pipe;
    logic [2:0]        inflight;
    logic [7:0]        credit;
    logic [CW-1:0]     count;
    logic              empty;
    logic              start;
    logic              issue;
    logic              hdr_push;
    logic              done;
    logic              push;
    logic              pop;
    logic [63:0]       push_data;

    assign start = I_c2h_en && !en_q;
    assign pop   = !empty && I_PXIE_TX_RDY;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, vld_pipe[i]};
        end
    end

    assign credit = 8'(count) + 8'(inflight);

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        hdr_push = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_HEAD;
            end
            ST_HEAD: begin
                hdr_push = 1'b1;
                state_d  = (rem_q == '0) ? ST_DRAIN : ST_READ;
            end
            ST_READ: begin
                if (rem_q != '0 && credit < 8'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (rem_q == 16'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    if (count == CW'(1) && pop) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (empty) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_PXIE_CLK) begin
        if (I_Rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge I_PXIE_CLK) begin
        if (I_Rst) begin
            en_q     <= 1'b0;
            cur_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            vld_pipe <= '0;
        end else begin
            en_q     <= I_c2h_en;
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(issue);
            if (state_q == ST_IDLE && start) begin
                cur_q <= I_c2h_addr;
                rem_q <= I_c2h_len;
            end
            if (issue) begin
                addr_q <= cur_q;
                cur_q  <= cur_q + 16'(ADDR_STEP);
                rem_q  <= rem_q - 16'd1;
            end
        end
    end

    // HEAD only follows IDLE, so header and RAM returns never collide
    assign push      = hdr_push || vld_pipe[RD_LAT-1];
    assign push_data = hdr_push ? c2h_header(rem_q, cur_q) : I_ram_data;

    pxie_c2h_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .I_PXIE_CLK (I_PXIE_CLK),
        .I_Rst      (I_Rst),
        .push       (push),
        .din        (push_data),
        .pop        (pop),
        .dout       (O_PXIE_TX_DATA),
        .count      (count),
        .empty      (empty)
    );

    assign O_PXIE_TX_VLD = !empty;
    assign O_ram_rden    = issue;
    assign O_ram_addr    = issue ? cur_q : addr_q;
    assign O_busy        = (state_q != ST_IDLE);
    assign O_done        = done;

endmodule

// File: tb/tb_pxie_c2h_reader.sv
// Directed bench for pxie_c2h_reader: vector table of frames
// plus backpressure, re-trigger and mid-frame reset sequences.
module tb_pxie_c2h_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] c2h_addr;
    logic [15:0] c2h_len;
    logic        c2h_en;
    logic [15:0] ram_addr;
    logic        ram_rden;
    logic [63:0] ram_data;
    logic [63:0] tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pxie_c2h_reader dut (
        .I_PXIE_CLK     (clk),
        .I_Rst          (rst),
        .I_c2h_addr     (c2h_addr),
        .I_c2h_len      (c2h_len),
        .I_c2h_en       (c2h_en),
        .O_ram_addr     (ram_addr),
        .O_ram_rden     (ram_rden),
        .I_ram_data     (ram_data),
        .O_PXIE_TX_DATA (tx_data),
        .O_PXIE_TX_VLD  (tx_vld),
        .I_PXIE_TX_RDY  (tx_rdy),
        .O_busy         (busy),
        .O_done         (done)
    );

    function automatic logic [63:0] ram_word(input logic [15:0] a);
        return {16'hDA7A, a, ~a, a ^ 16'h5A5A};
    endfunction

    // RAM model: data for the address strobed two cycles earlier
    logic [15:0] rp0 = '0;
    logic [15:0] rp1 = '0;
    always @(posedge clk) begin
        rp1 <= rp0;
        rp0 <= ram_addr;
    end
    assign ram_data = ram_word(rp1);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] tx_q[$];
    int          txc_q[$];
    logic [15:0] rd_q[$];
    int          rdc_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        logic [63:0] hdr;
        logic [15:0] last;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sample();
        if (tx_vld && tx_rdy) begin
            tx_q.push_back(tx_data);
            txc_q.push_back(cyc);
        end
        if (ram_rden) begin
            rd_q.push_back(ram_addr);
            rdc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Sample at negedge, then move to just after the next posedge
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr();
        tx_q.delete();
        txc_q.delete();
        rd_q.delete();
        rdc_q.delete();
    endtask

    task automatic start_frame(input logic [15:0] a,
                               input logic [15:0] l,
                               output int n);
        c2h_addr = a;
        c2h_len  = l;
        c2h_en   = 1'b1;
        n        = cyc;
        tick();
        c2h_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int s;
        int k;
        s = done_cnt;
        k = 0;
        while (done_cnt == s && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", 64'(done_cnt != s), 64'd1);
    endtask

    task automatic chk_frame(input logic [15:0] a, input int len,
                             input logic [63:0] hdr);
        logic [15:0] ea;
        chk("nwords", 64'(tx_q.size()), 64'(len + 1));
        if (tx_q.size() > 0) chk("header", tx_q[0], hdr);
        for (int i = 0; i < len; i++) begin
            ea = a + 16'(2 * i);
            if (i + 1 < tx_q.size()) chk("data", tx_q[i+1], ram_word(ea));
        end
        chk("nreads", 64'(rd_q.size()), 64'(len));
        for (int i = 0; i < rd_q.size(); i++) begin
            ea = a + 16'(2 * i);
            chk("rd_addr", 64'(rd_q[i]), 64'(ea));
        end
    endtask

    initial begin
        int n;
        int gaps;
        int unstable;
        int d0;
        logic [15:0] held;

        vt[0] = '{16'h0010, 16'd4, 64'hEB9C_0004_0010_1010, 16'h0016};
        vt[1] = '{16'h1234, 16'd0, 64'hEB9C_0000_1234_1010, 16'h0000};
        vt[2] = '{16'hFFFE, 16'd2, 64'hEB9C_0002_FFFE_1010, 16'h0000};
        vt[3] = '{16'h0100, 16'd1, 64'hEB9C_0001_0100_1010, 16'h0100};
        vt[4] = '{16'hA5A4, 16'd7, 64'hEB9C_0007_A5A4_1010, 16'hA5B0};

        rst      = 1'b1;
        c2h_addr = '0;
        c2h_len  = '0;
        c2h_en   = 1'b0;
        tx_rdy   = 1'b1;
        repeat (3) tick();
        chk("rst_vld",  64'(tx_vld),   64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_done", 64'(done),     64'd0);
        chk("rst_data", tx_data,       64'd0);
        chk("rst_rden", 64'(ram_rden), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        rst = 1'b0;
        tick();
        clr();

        for (int v = 0; v < 5; v++) begin
            clr();
            start_frame(vt[v].addr, vt[v].len, n);
            wait_done(200);
            chk("busy_after", 64'(busy), 64'd0);
            chk("vld_after", 64'(tx_vld), 64'd0);
            chk_frame(vt[v].addr, int'(vt[v].len), vt[v].hdr);
            if (vt[v].len > 0 && rd_q.size() == int'(vt[v].len)) begin
                chk("last_addr", 64'(rd_q[vt[v].len-1]), 64'(vt[v].last));
            end
            if (txc_q.size() > 0) begin
                chk("done_on_last", 64'(done_cyc), 64'(txc_q[$]));
            end
            if (v == 0 && txc_q.size() > 1 && rdc_q.size() > 0) begin
                chk("lat_hdr",   64'(txc_q[0]), 64'(n + 2));
                chk("lat_rden",  64'(rdc_q[0]), 64'(n + 2));
                chk("lat_data0", 64'(txc_q[1]), 64'(n + 5));
            end
            tick();
        end

        // Backpressure: sink stalled while the frame starts
        clr();
        tx_rdy = 1'b0;
        start_frame(16'h0200, 16'd16, n);
        tick();
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            if (!tx_vld || tx_data !== 64'hEB9C_0010_0200_1010) unstable++;
            tick();
        end
        chk("stall_stable", 64'(unstable), 64'd0);
        chk("stall_reads", 64'(rd_q.size()), 64'd3);
        held = ram_addr;
        chk("stall_addr_hold", 64'(held), 64'h0204);
        tx_rdy = 1'b1;
        wait_done(200);
        chk_frame(16'h0200, 16, 64'hEB9C_0010_0200_1010);
        gaps = 0;
        for (int i = 1; i < txc_q.size(); i++) begin
            if (txc_q[i] != txc_q[i-1] + 1) gaps++;
        end
        chk("stream_gaps", 64'(gaps), 64'd0);
        tick();

        // Re-trigger while busy is ignored; after done it starts a frame
        clr();
        d0 = done_cnt;
        start_frame(16'h0300, 16'd8, n);
        repeat (3) tick();
        c2h_addr = 16'h0500;
        c2h_len  = 16'd3;
        c2h_en   = 1'b1;
        tick();
        c2h_en   = 1'b0;
        wait_done(200);
        repeat (10) tick();
        chk("retrig_dones", 64'(done_cnt - d0), 64'd1);
        chk_frame(16'h0300, 8, 64'hEB9C_0008_0300_1010);
        clr();
        start_frame(16'h0700, 16'd2, n);
        wait_done(200);
        chk_frame(16'h0700, 2, 64'hEB9C_0002_0700_1010);
        tick();

        // Reset in the middle of READ
        clr();
        start_frame(16'h0400, 16'd16, n);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mrst_vld",  64'(tx_vld), 64'd0);
        chk("mrst_busy", 64'(busy),   64'd0);
        chk("mrst_data", tx_data,     64'd0);
        rst = 1'b0;
        clr();
        repeat (6) tick();
        chk("mrst_no_late", 64'(tx_q.size()), 64'd0);
        chk("mrst_vld_late", 64'(tx_vld), 64'd0);
        clr();
        start_frame(16'h0600, 16'd1, n);
        wait_done(200);
        chk_frame(16'h0600, 1, 64'hEB9C_0001_0600_1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
